mem_access_ctrl: RTL and testbench

Sequences every data-memory load/store issued by the MIPS pipeline's MEM stage.
- Accepts one request at a time, checks alignment, and drives a valid/ready request channel to data memory with a word address and byte strobes.
- Waits for read data, then returns sign/zero-extended or LWL/LWR-merged load data to writeback.
- Holds the pipeline stalled while an access is outstanding.

---
 rtl/mem_ops_pkg.sv | 56 +++++
 rtl/lsu_lane_steer.sv | 78 +++++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ops_pkg.sv
// Shared encodings for the MEM-stage load/store path: op codes, response
// error codes, controller states and the small decode helpers used at accept.
package mem_ops_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd3,
        OP_LHU = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SWL = 4'd11,
        OP_SWR = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_ADEL = 2'b01,
        ERR_ADES = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Unknown encodings behave as a plain word load.
    function automatic op_e norm_op(input logic [3:0] raw);
        case (raw)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: norm_op = op_e'(raw);
            default:                         norm_op = OP_LW;
        endcase
    endfunction

    function automatic logic is_store(input op_e op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
                   (op == OP_SWL) || (op == OP_SWR);
    endfunction

    function automatic logic misaligned(input op_e op, input logic [1:0] ea);
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = ea[0];
            OP_LW, OP_SW:         misaligned = |ea;
            default:              misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Little-endian byte-lane steering: store strobes/data toward memory and
// load extraction/merge (including LWL/LWR) from the returned word.
module lsu_lane_steer
    import mem_ops_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  ea_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [31:0] rd_shr;
    logic [7:0]  byte_m;
    logic [15:0] half_m;

    assign sh_lo  = {ea_i, 3'b000};
    assign sh_hi  = {~ea_i, 3'b000};
    assign rd_shr = rdata_i >> sh_lo;
    assign byte_m = rd_shr[7:0];
    assign half_m = ea_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wen_o   = 4'b0000;
        wdata_o = 32'h0;
        ldata_o = rdata_i;
        case (op_i)
            OP_SB: begin
                wen_o   = 4'b0001 << ea_i;
                wdata_o = {4{rt_i[7:0]}};
            end
            OP_SH: begin
                wen_o   = ea_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = ea_i[1] ? {rt_i[15:0], 16'h0} : {16'h0, rt_i[15:0]};
            end
            OP_SW: begin
                wen_o   = 4'b1111;
                wdata_o = rt_i;
            end
            OP_SWL: begin
                wen_o   = 4'b1111 >> (~ea_i);
                wdata_o = rt_i >> sh_hi;
            end
            OP_SWR: begin
                wen_o   = 4'b1111 << ea_i;
                wdata_o = rt_i << sh_lo;
            end
            OP_LB:  ldata_o = {{24{byte_m[7]}}, byte_m};
            OP_LBU: ldata_o = {24'h0, byte_m};
            OP_LH:  ldata_o = {{16{half_m[15]}}, half_m};
            OP_LHU: ldata_o = {16'h0, half_m};
            // Unaligned word halves: memory bytes fill from the top (LWL)
            // or bottom (LWR), the rest of rt is preserved.
            OP_LWL: begin
                case (ea_i)
                    2'd0: ldata_o = {rdata_i[7:0],  rt_i[23:0]};
                    2'd1: ldata_o = {rdata_i[15:0], rt_i[15:0]};
                    2'd2: ldata_o = {rdata_i[23:0], rt_i[7:0]};
                    2'd3: ldata_o = rdata_i;
                endcase
            end
            OP_LWR: begin
                case (ea_i)
                    2'd0: ldata_o = rdata_i;
                    2'd1: ldata_o = {rt_i[31:24], rdata_i[31:8]};
                    2'd2: ldata_o = {rt_i[31:16], rdata_i[31:16]};
                    2'd3: ldata_o = {rt_i[31:8],  rdata_i[31:24]};
                endcase
            end
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one access at a time over a valid/ready
// memory channel, with alignment faults, a bounded wait and a held response.
module mem_access_ctrl
    import mem_ops_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_rt,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    output logic        stall
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rt_q, rt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    err_e        err_q, err_d;

    logic [3:0]  st_wen;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [7:0]  cnt_inc;
    logic        expired;
    op_e         in_op;

    lsu_lane_steer u_steer (
        .op_i    (op_q),
        .ea_i    (addr_q[1:0]),
        .rt_i    (rt_q),
        .rdata_i (mem_rdata),
        .wen_o   (st_wen),
        .wdata_o (st_wdata),
        .ldata_o (ld_data)
    );

    assign in_op   = norm_op(req_op);
    assign cnt_inc = cnt_q + 8'd1;
    assign expired = (cnt_inc == TMO_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            rt_q    <= 32'h0;
            cnt_q   <= 8'h0;
            data_q  <= 32'h0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rt_d    = rt_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = in_op;
                    addr_d = req_addr;
                    rt_d   = req_rt;
                    cnt_d  = 8'h0;
                    data_d = 32'h0;
                    err_d  = ERR_NONE;
                    if (misaligned(in_op, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = is_store(in_op) ? ERR_ADES : ERR_ADEL;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A handshake landing on the expiry cycle still completes.
                if (mem_ready) begin
                    cnt_d   = 8'h0;
                    state_d = is_store(op_q) ? RESP : WAIT_R;
                end else if (expired) begin
                    state_d = RESP;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    data_d  = ld_data;
                    state_d = RESP;
                end else if (expired) begin
                    state_d = RESP;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q != IDLE) || req_valid;
    assign mem_valid  = (state_q == ISSUE);
    assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wen    = mem_valid ? st_wen : 4'b0000;
    assign mem_wdata  = mem_valid ? st_wdata : 32'h0;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single transactions plus
// hand-written timeout, response back-pressure and mid-access reset cases.
module tb_mem_access_ctrl;
    import mem_ops_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_rt;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_rt     (req_rt),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] w);
        lane_mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rt    = rt;
        #1;
        chk("acc_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string t;
        v = vecs[i];
        t = $sformatf("v%0d", i);
        accept(v.op, v.addr, v.rt);
        if (v.err != 2'b00) begin
            chk({t, "_no_mem"}, 32'(mem_valid), 32'd0);
        end else begin
            chk({t, "_mem_valid"}, 32'(mem_valid), 32'd1);
            chk({t, "_mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
            chk({t, "_mem_wen"}, 32'(mem_wen), 32'(v.wen));
            if (v.wen != 4'b0000)
                chk({t, "_mem_wdata"}, mem_wdata & lane_mask(v.wen), v.wdata & lane_mask(v.wen));
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            if (v.wen == 4'b0000) begin
                chk({t, "_wait_no_resp"}, 32'(resp_valid), 32'd0);
                chk({t, "_wait_no_mem"}, 32'(mem_valid), 32'd0);
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                step();
                mem_rvalid = 1'b0;
            end
        end
        chk({t, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({t, "_resp_err"}, 32'(resp_err), 32'(v.err));
        chk({t, "_resp_data"}, resp_data, v.data);
        release_resp(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //               op      addr          rt            rdata         wen    wdata         data          err
        vecs[0]  = '{OP_SW,  32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        4'hF, 32'hDEAD_BEEF, 32'h0,        2'b00};
        vecs[1]  = '{OP_LB,  32'h0000_2003, 32'h0,        32'h80FF_0000, 4'h0, 32'h0,        32'hFFFF_FF80, 2'b00};
        vecs[2]  = '{OP_LBU, 32'h0000_2003, 32'h0,        32'h80FF_0000, 4'h0, 32'h0,        32'h0000_0080, 2'b00};
        vecs[3]  = '{OP_LWL, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 4'h0, 32'h0,       32'hCCDD_3344, 2'b00};
        vecs[4]  = '{OP_SWR, 32'h0000_3002, 32'h1122_3344, 32'h0,        4'hC, 32'h3344_0000, 32'h0,        2'b00};
        vecs[5]  = '{OP_LH,  32'h0000_4001, 32'h0,        32'h0,         4'h0, 32'h0,        32'h0,         2'b01};
        vecs[6]  = '{OP_SW,  32'h0000_4002, 32'h1234_5678, 32'h0,        4'h0, 32'h0,        32'h0,         2'b10};
        vecs[7]  = '{OP_LH,  32'h0000_5002, 32'h0,        32'h8001_1234, 4'h0, 32'h0,        32'hFFFF_8001, 2'b00};
        vecs[8]  = '{OP_LHU, 32'h0000_5002, 32'h0,        32'h8001_1234, 4'h0, 32'h0,        32'h0000_8001, 2'b00};
        vecs[9]  = '{OP_SB,  32'h0000_6001, 32'h0000_00A5, 32'h0,        4'h2, 32'h0000_A500, 32'h0,        2'b00};
        vecs[10] = '{OP_SWL, 32'h0000_7001, 32'h1122_3344, 32'h0,        4'h3, 32'h0000_1122, 32'h0,        2'b00};
        vecs[11] = '{OP_LWR, 32'h0000_7002, 32'h1122_3344, 32'hAABB_CCDD, 4'h0, 32'h0,       32'h1122_AABB, 2'b00};
        vecs[12] = '{OP_LW,  32'h0000_8000, 32'h0,        32'h1234_5678, 4'h0, 32'h0,        32'h1234_5678, 2'b00};
        vecs[13] = '{OP_SH,  32'h0000_8002, 32'h0000_BEEF, 32'h0,        4'hC, 32'hBEEF_0000, 32'h0,        2'b00};
        vecs[14] = '{4'hF,   32'h0000_9000, 32'h0,        32'hCAFE_BABE, 4'h0, 32'h0,        32'hCAFE_BABE, 2'b00};
        vecs[15] = '{4'hF,   32'h0000_9001, 32'h0,        32'h0,         4'h0, 32'h0,        32'h0,         2'b01};
        vecs[16] = '{OP_LWL, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 4'h0, 32'h0,       32'hAABB_CCDD, 2'b00};
        vecs[17] = '{OP_LWR, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 4'h0, 32'h0,       32'h11AA_BBCC, 2'b00};
        vecs[18] = '{OP_SWL, 32'h0000_7003, 32'h1122_3344, 32'h0,        4'hF, 32'h1122_3344, 32'h0,        2'b00};

        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'h0;
        req_addr   = 32'h0;
        req_rt     = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        resp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 19; i++) run_vec(i);

        // ISSUE timeout: four cycles with mem_valid, then error response
        accept(OP_SW, 32'h0000_A000, 32'h5555_AAAA);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("tmo_issue_valid_c%0d", c), 32'(mem_valid), 32'd1);
            step();
        end
        chk("tmo_issue_resp", 32'(resp_valid), 32'd1);
        chk("tmo_issue_err", 32'(resp_err), 32'd3);
        chk("tmo_issue_data", resp_data, 32'h0);
        chk("tmo_issue_mem_drop", 32'(mem_valid), 32'd0);
        release_resp("tmo_issue");

        // Handshake on the expiry cycle wins
        accept(OP_SW, 32'h0000_A004, 32'h0102_0304);
        for (int c = 0; c < 3; c++) step();
        chk("race_still_issue", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("race_resp", 32'(resp_valid), 32'd1);
        chk("race_err", 32'(resp_err), 32'd0);
        release_resp("race");

        // WAIT_R timeout: read data never returns
        accept(OP_LW, 32'h0000_B000, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("tmo_wait_idle_c%0d", c), 32'(resp_valid), 32'd0);
            step();
        end
        chk("tmo_wait_resp", 32'(resp_valid), 32'd1);
        chk("tmo_wait_err", 32'(resp_err), 32'd3);
        release_resp("tmo_wait");

        // Response held under back-pressure
        accept(OP_LW, 32'h0000_C004, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold_valid_c%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("hold_data_c%0d", c), resp_data, 32'h0BAD_F00D);
            chk($sformatf("hold_stall_c%0d", c), 32'(stall), 32'd1);
            chk($sformatf("hold_req_ready_c%0d", c), 32'(req_ready), 32'd0);
            step();
        end
        release_resp("hold");

        // Reset during WAIT_R abandons the access; late rvalid is ignored
        accept(OP_LW, 32'h0000_D000, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        resetn    = 1'b0;
        #1;
        chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_data", resp_data, 32'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        step();
        resetn     = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid_resp", 32'(resp_valid), 32'd0);
        chk("late_rvalid_req_ready", 32'(req_ready), 32'd1);
        chk("late_rvalid_stall", 32'(stall), 32'd0);
        chk("late_rvalid_data", resp_data, 32'h0);
        step();
        chk("late_rvalid_resp2", 32'(resp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
